data_accumulator: RTL

DATA_ACCUMULATOR -- requirements
Module: data_accumulator

---
 rtl/data_accumulator.sv | 122 ++++++++++++
 1 files changed

// File: rtl/data_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : data_accumulator
// Description : Sweeps a word address 0..LAST_ADDR over an upstream memory and
//               accumulates the returned signed words into a 12-bit sum.
//               Optional max/min tracking is enabled by defining MAXMIN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module data_accumulator #(
    parameter int LAST_ADDR = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [3:0]         counter,
    input  logic signed [7:0]  data,
    output logic signed [11:0] sum,
    output logic               busy,
    output logic               done
`ifdef MAXMIN_EN
    ,
    output logic signed [7:0]  max_val,
    output logic signed [7:0]  min_val
`endif
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ACC  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;
    localparam logic [3:0] c_LAST = 4'(LAST_ADDR);

    logic [1:0]         r_state;
    logic [3:0]         r_counter;
    logic signed [11:0] r_sum;
    logic               r_busy;
    logic               r_done;

    logic               w_launch;
    logic               w_acc;
    logic signed [11:0] w_data_ext;

    // start is only honoured from a resting state; during a sweep it is ignored
    assign w_launch   = start && ((r_state == c_IDLE) || (r_state == c_DONE));
    assign w_acc      = (r_state == c_ACC);
    assign w_data_ext = {{4{data[7]}}, data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_counter <= 4'd0;
            r_sum     <= 12'sd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (w_launch) begin
                        r_state   <= c_ACC;
                        r_counter <= 4'd0;
                        r_sum     <= 12'sd0;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                    end
                end
                c_ACC: begin
                    r_sum <= r_sum + w_data_ext;
                    // counter parks on the last address so it never overruns the image
                    if (r_counter == c_LAST) begin
                        r_state <= c_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_counter <= r_counter + 4'd1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign counter = r_counter;
    assign sum     = r_sum;
    assign busy    = r_busy;
    assign done    = r_done;

`ifdef MAXMIN_EN
    logic signed [7:0] r_max;
    logic signed [7:0] r_min;
    logic              r_first;

    // the first word of a sweep seeds both extremes, later words compare
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max   <= 8'sd0;
            r_min   <= 8'sd0;
            r_first <= 1'b0;
        end else if (w_launch) begin
            r_max   <= 8'sd0;
            r_min   <= 8'sd0;
            r_first <= 1'b1;
        end else if (w_acc) begin
            r_first <= 1'b0;
            if (r_first) begin
                r_max <= data;
                r_min <= data;
            end else begin
                if (data > r_max) r_max <= data;
                if (data < r_min) r_min <= data;
            end
        end
    end

    assign max_val = r_max;
    assign min_val = r_min;
`endif

endmodule
`default_nettype wire
